// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl -- Montgomery modular-exponentiation sequencer (x^e mod m).
//
// Left-to-right square-and-multiply. All wide arithmetic is delegated to an
// external Montgomery multiplier, MontMul(a,b) = a*b*R^-1 mod m, R = 2^WIDTH,
// driven through a mul_start / mul_done handshake. The modulus is wired to the
// multiplier by the parent.
//
// Optional build macro: MONT_EXP_CONST_TIME_EN
//   defined   : no leading-zero skip; every exponent bit does SQR then MUL.
//               On a 0 bit the MUL result is discarded, so latency does not
//               depend on the exponent.
//   undefined : leading exponent zeros are skipped and MUL runs only on 1 bits.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request, sampled only while idle
//   x, exponent         base (< m) and exponent, captured at accepted start
//   rmodm, r2modm       R mod m and R^2 mod m, captured at accepted start
//   busy                high from the cycle after accept until done
//   done                one-cycle pulse, result valid
//   result              x^e mod m, held until the next accepted start
//   mul_start           one-cycle pulse to the multiplier
//   mul_a, mul_b        multiplier operands, stable until mul_done
//   mul_done            one-cycle pulse from the multiplier
//   mul_result          MontMul(mul_a, mul_b), valid with mul_done
module mont_exp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     rmodm,
  input  logic [WIDTH-1:0]     r2modm,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [WIDTH-1:0]     mul_result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_SQR  = 3'd3;
  localparam logic [2:0] S_MUL  = 3'd4;
  localparam logic [2:0] S_POST = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]           state;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_dn;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     xm_q;
  logic [WIDTH-1:0]     a_new;
  logic                 exp_bit;
  logic                 op_state;
  logic                 capture;
`ifdef MONT_EXP_CONST_TIME_EN
  logic [WIDTH-1:0]     discard_q;
`else
  logic                 next_bit;
`endif

  // The issue cycle is the one with mul_start high; every other cycle of an
  // op state is the wait phase, so no separate phase register is needed.
  assign op_state = (state == S_PRE) || (state == S_SQR) ||
                    (state == S_MUL) || (state == S_POST);
  assign capture  = op_state && !mul_start && mul_done;

  always_comb begin
    exp_bit = exp_q[idx];
    idx_dn  = (idx != '0) ? (idx - IDX_W'(1)) : '0;
    a_new   = mul_result;
`ifdef MONT_EXP_CONST_TIME_EN
    // Dummy multiply on a 0 bit leaves the accumulator untouched.
    if ((state == S_MUL) && !exp_bit) a_new = a_q;
`else
    next_bit = (idx != '0) ? exp_q[idx_dn] : 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      exp_q     <= '0;
      idx       <= '0;
      a_q       <= '0;
      xm_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
`ifdef MONT_EXP_CONST_TIME_EN
      discard_q <= '0;
`endif
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          // x and r2modm are held directly in the operand registers for PRE.
          exp_q     <= exponent;
          idx       <= IDX_TOP;
          a_q       <= rmodm;
          mul_a     <= x;
          mul_b     <= r2modm;
          mul_start <= 1'b1;
          busy      <= 1'b1;
          state     <= S_PRE;
        end
        S_PRE: if (capture) begin
          xm_q  <= mul_result;
          state <= S_SCAN;
        end
        S_SCAN: begin
`ifdef MONT_EXP_CONST_TIME_EN
          mul_a     <= a_q;
          mul_b     <= a_q;
          mul_start <= 1'b1;
          state     <= S_SQR;
`else
          // Looks one bit ahead so the first set bit is reached without an
          // extra cycle after the final decrement.
          if (exp_bit) begin
            mul_a     <= a_q;
            mul_b     <= a_q;
            mul_start <= 1'b1;
            state     <= S_SQR;
          end else if (idx != '0) begin
            idx <= idx_dn;
            if (next_bit) begin
              mul_a     <= a_q;
              mul_b     <= a_q;
              mul_start <= 1'b1;
              state     <= S_SQR;
            end
          end else begin
            mul_a     <= a_q;
            mul_b     <= ONE;
            mul_start <= 1'b1;
            state     <= S_POST;
          end
`endif
        end
        S_SQR: if (capture) begin
          a_q <= a_new;
`ifdef MONT_EXP_CONST_TIME_EN
          if (1'b1) begin
`else
          if (exp_bit) begin
`endif
            mul_a     <= a_new;
            mul_b     <= xm_q;
            mul_start <= 1'b1;
            state     <= S_MUL;
          end else if (idx == '0) begin
            mul_a     <= a_new;
            mul_b     <= ONE;
            mul_start <= 1'b1;
            state     <= S_POST;
          end else begin
            idx       <= idx_dn;
            mul_a     <= a_new;
            mul_b     <= a_new;
            mul_start <= 1'b1;
            state     <= S_SQR;
          end
        end
        S_MUL: if (capture) begin
          a_q <= a_new;
`ifdef MONT_EXP_CONST_TIME_EN
          if (!exp_bit) discard_q <= mul_result;
`endif
          if (idx == '0) begin
            mul_a     <= a_new;
            mul_b     <= ONE;
            mul_start <= 1'b1;
            state     <= S_POST;
          end else begin
            idx       <= idx_dn;
            mul_a     <= a_new;
            mul_b     <= a_new;
            mul_start <= 1'b1;
            state     <= S_SQR;
          end
        end
        S_POST: if (capture) begin
          result <= mul_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl at WIDTH=8, EXP_WIDTH=8 with a
// behavioural Montgomery multiplier (m=0xC5, latency 3) and an arithmetic
// reference for x^e mod m, op count and latency.
module tb_mont_exp_ctrl;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int M  = 197;
  localparam int D  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  x;
  logic [EW-1:0] exponent;
  logic [W-1:0]  rmodm;
  logic [W-1:0]  r2modm;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          mul_start;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_done;
  logic [W-1:0]  mul_result;

  logic          mm_done;
  logic          spur;
  int            mm_cnt;
  int            pa, pb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .exponent(exponent),
    .rmodm(rmodm), .r2modm(r2modm), .busy(busy), .done(done), .result(result),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  // MontMul(a,b): the t in [0,m) with t*R == a*b (mod m).
  function automatic int mont(input int a, input int b);
    for (int t = 0; t < M; t++)
      if (((t * 256) % M) == ((a * b) % M)) return t;
    return 0;
  endfunction

  function automatic int ref_pow(input int xv, input int ev);
    int r = 1 % M;
    for (int i = 0; i < ev; i++) r = (r * xv) % M;
    return r;
  endfunction

  function automatic int msb_pos(input int ev);
    int p = -1;
    for (int i = 0; i < EW; i++) if ((ev >> i) & 1) p = i;
    return p;
  endfunction

  function automatic int ref_ops(input int ev);
    int hw = 0;
`ifdef MONT_EXP_CONST_TIME_EN
    return 2 + 2 * EW;
`else
    if (ev == 0) return 2;
    for (int i = 0; i < EW; i++) hw += (ev >> i) & 1;
    return 2 + (msb_pos(ev) + 1) + hw;
`endif
  endfunction

  function automatic int ref_scan(input int ev);
`ifdef MONT_EXP_CONST_TIME_EN
    return 1;
`else
    if (ev == 0) return EW;
    return (EW - 1 - msb_pos(ev) < 1) ? 1 : EW - 1 - msb_pos(ev);
`endif
  endfunction

  // Behavioural multiplier: mul_done D cycles after the mul_start cycle.
  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (mul_start) begin
      mm_cnt <= D - 1;
      pa     <= int'(mul_a);
      pb     <= int'(mul_b);
    end else if (mm_cnt > 1) begin
      mm_cnt <= mm_cnt - 1;
    end else if (mm_cnt == 1) begin
      mm_done    <= 1'b1;
      mul_result <= W'(mont(pa, pb));
      mm_cnt     <= 0;
    end
  end
  assign mul_done = mm_done | spur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Starts in the current (idle) cycle and waits for done. With storm set,
  // start and the data inputs are randomised every busy cycle.
  task automatic run_exp(input string tag, input int xv, input int ev, input bit storm);
    int cyc = 0, nmul = 0, busy_bad = 0;
    bit got = 0;
    x = W'(xv); exponent = EW'(ev); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      cyc++;
      if (mul_start) nmul++;
      if (done) begin
        got = 1;
        if (busy) busy_bad++;
      end else begin
        if (!busy) busy_bad++;
        if (storm) begin
          start = 1'($urandom_range(0, 1));
          x = W'($urandom); exponent = EW'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " result"}, 32'(result), 32'(ref_pow(xv, ev)));
    check({tag, " ops"}, 32'(nmul), 32'(ref_ops(ev)));
    check({tag, " latency"}, 32'(cyc), 32'(1 + ref_scan(ev) + ref_ops(ev) * (D + 1)));
    check({tag, " busy"}, 32'(busy_bad), 32'd0);
  endtask

  // Quiet cycles after a run: no done, no multiplier traffic, result held.
  task automatic idle_check(input string tag, input int n, input int res, input bit pulse_spur);
    int nd = 0, nm = 0, nb = 0;
    for (int i = 0; i < n; i++) begin
      spur = pulse_spur && (i == 3);
      @(posedge clk); #1;
      if (done) nd++;
      if (mul_start) nm++;
      if (busy) nb++;
    end
    spur = 1'b0;
    check({tag, " extra_done"}, 32'(nd), 32'd0);
    check({tag, " extra_mul"}, 32'(nm), 32'd0);
    check({tag, " idle_busy"}, 32'(nb), 32'd0);
    check({tag, " held"}, 32'(result), 32'(res));
  endtask

  initial begin
    int xr, er, nm;
    bit hit;
    reset = 1'b1; start = 1'b0; spur = 1'b0;
    x = '0; exponent = '0; rmodm = 8'h3B; r2modm = 8'h84;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst mul_start", 32'(mul_start), 32'd0);
    check("rst mul_a", 32'(mul_a), 32'd0);
    check("rst mul_b", 32'(mul_b), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_exp("x2e0A", 2, 8'h0A, 0);
    check("x2e0A const", 32'(result), 32'h27);
    idle_check("x2e0A", 12, 8'h27, 0);

    run_exp("e00", 2, 8'h00, 0);
    check("e00 const", 32'(result), 32'h01);
    idle_check("e00", 6, 8'h01, 0);

    run_exp("e01", 2, 8'h01, 0);
    check("e01 const", 32'(result), 32'h02);
    idle_check("e01", 6, 8'h02, 0);

    run_exp("eFF", 1, 8'hFF, 0);
    check("eFF const", 32'(result), 32'h01);
    idle_check("eFF", 6, 8'h01, 0);

    // Start requests (including one coinciding with done) must be ignored.
    run_exp("storm", 2, 8'h0A, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle_check("storm", 12, 8'h27, 0);

    // Abort with reset in the wait phase of the third op.
    x = 8'h02; exponent = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nm = 0; hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (mul_start) nm++;
      if (nm == 3) hit = 1;
      @(posedge clk); #1;
    end
    check("abort reached", 32'(hit), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort mul_start", 32'(mul_start), 32'd0);
    check("abort result", 32'(result), 32'd0);
    reset = 1'b0;
    idle_check("abort", 12, 0, 1);
    run_exp("after_abort", 2, 8'h0A, 0);
    check("after_abort const", 32'(result), 32'h27);

    // Back-to-back: second start in the first idle cycle after done.
    @(posedge clk); #1;
    check("b2b held", 32'(result), 32'h27);
    run_exp("b2b", 5, 8'h0D, 0);

    for (int t = 0; t < 16; t++) begin
      xr = int'($urandom_range(0, M - 1));
      er = int'($urandom_range(0, 255));
      @(posedge clk); #1;
      run_exp("rand", xr, er, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

Parametrised Montgomery modular-exponentiation sequencer computing x^e mod m with left-to-right square-and-multiply. It drives an external Montgomery multiplier, MontMul(a,b) = a·b·R⁻¹ mod m with R = 2^WIDTH, through a start/done handshake and never does wide arithmetic itself. It generalises the fixed 512-bit exponentiation engine in three ways: operand width and exponent width are parameters, leading exponent zeros are skipped, and a host busy/done handshake is provided. The parent wires the modulus directly to the multiplier.

## Interface
- WIDTH, 512: operand width in bits; R = 2^WIDTH.
- EXP_WIDTH, 512: exponent width in bits, ≥ 1.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  WIDTH  base, < m; captured at accepted start.
- exponent  in  EXP_WIDTH  captured at accepted start.
- rmodm  in  WIDTH  R mod m; captured at accepted start.
- r2modm  in  WIDTH  R² mod m; captured at accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  x^e mod m; held from done until next accepted start.
- mul_start  out  1  one-cycle pulse to the multiplier.
- mul_a, mul_b  out  WIDTH each  multiplier operands; stable from mul_start until mul_done.
- mul_done  in  1  one-cycle pulse; mul_result valid in that cycle.
- mul_result  in  WIDTH  MontMul(mul_a, mul_b).

## Operation
- States: IDLE, PRE, SCAN, SQR, MUL, POST, DONE. Each op state has an ISSUE cycle (mul_start=1) and a WAIT phase (capture on mul_done).
- IDLE: on start=1, latch x, exponent, rmodm, r2modm. Set idx = EXP_WIDTH-1 and A = rmodm. Go to PRE.
- PRE: Xm = MontMul(x, r2modm). Go to SCAN.
- SCAN: while exponent[idx]=0 and idx>0, decrement idx (one cycle per bit). Then if exponent[idx]=1 go to SQR, else go to POST (e=0 case).
- SQR: A = MontMul(A, A). If exponent[idx]=1 go to MUL, else go to step.
- MUL: A = MontMul(A, Xm). Go to step.
- step: if idx=0 go to POST, else decrement idx and go to SQR.
- POST: result = MontMul(A, 1). Go to DONE.
- DONE: assert done for one cycle, busy=0, then go to IDLE.
- start while not in IDLE: ignored, not queued.
- mul_done outside a WAIT phase: ignored.
- mul_start is never reasserted before the matching mul_done.
- e=0 yields 1. Operands ≥ m: undefined result, but the FSM still terminates.

## Timing
- Reset values: busy=0, done=0, result=0, mul_start=0, mul_a=0, mul_b=0. FSM goes to IDLE; idx, A and Xm are cleared.
- Reset mid-operation aborts within one cycle. Any late mul_done is ignored.
- Accept at edge k. The PRE issue cycle (mul_start=1) is cycle k+1.
- Multiplier latency D ≥ 1: mul_done arrives D cycles after mul_start. The next issue follows in the cycle after mul_done, so each op costs D+1 cycles.
- Let p = index of the MSB set bit of e, and hw = popcount(e).
- Ops = 2 + (p+1) + hw.
- SCAN cycles = EXP_WIDTH-1-p (at least 1).
- Total, accept to done = 1 + SCAN + ops·(D+1).
- For e=0: ops = 2 and SCAN = EXP_WIDTH.
- A start in the same cycle as done is ignored; the FSM is not yet back in IDLE.

## Configuration
- MONT_EXP_CONST_TIME_EN defined:
  - SCAN is bypassed (always 1 cycle, idx = EXP_WIDTH-1).
  - Every bit performs SQR then MUL. When the bit is 0 the MUL result goes to a discard register and A is unchanged.
  - Ops = 2 + 2·EXP_WIDTH regardless of e, so latency is data-independent.
- Undefined: leading-zero skip and conditional MUL as described above.

## Test plan
Bench: WIDTH=8, EXP_WIDTH=8, m=0xC5, rmodm=0x3B, r2modm=0x84, behavioural multiplier with D=3.
- x=0x02, e=0x0A → result=0x27; 8 ops; done 1+4+32=37 cycles after accept (macro: 18 ops, 1+1+72=74 cycles).
- e=0x00, x=0x02 → result=0x01; exactly 2 mul_start pulses.
- e=0x01, x=0x02 → result=0x02; e=0xFF, x=0x01 → result=0x01.
- start pulsed repeatedly while busy → exactly one done, result unchanged from uninterrupted run.
- reset asserted during the 3rd WAIT → next cycle busy=0, mul_start=0, result=0; spurious mul_done afterwards ignored; new start with x=0x02, e=0x0A completes with 0x27.
- Back-to-back: second start asserted the cycle after done → accepted; result of first run held until then.
